load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sequencer between the datapath and the 16-entry byte/word data memory.
- Accepts one load or store request at a time over a valid/ready handshake and drives the memory's address, write-data and write-mode ports.
- Captures read data, extends byte loads to 16 bits and returns a response over a second valid/ready handshake.
- Keeps saturating load/store counters for debug.

Parameters:
- CNT_W, 8, width of load_cnt and store_cnt.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_op  in  2  00 load byte, 01 store byte, 10 store word, 11 load word
- req_signed  in  1  byte load: 1 sign-extend, 0 zero-extend; ignored otherwise
- req_addr  in  4  memory entry address
- req_wdata  in  16  store data; store byte uses bits [8:0]
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_data  out  16  load result; 0 for stores
- resp_is_load  out  1  1 if response belongs to a load
- mem_ReadAdd  out  4  memory address
- mem_WriteByte  out  9  memory byte write data
- mem_WriteWord  out  16  memory word write data
- mem_MemW  out  2  memory write mode: 00 none, 01 byte, 10 word
- mem_Byte  in  9  memory combinational byte read data
- mem_Word  in  16  memory combinational word read data
- load_cnt  out  CNT_W  completed loads, saturating
- store_cnt  out  CNT_W  completed stores, saturating

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Outputs while rst is high or after its release:
  - req_ready=0 while rst is high; otherwise req_ready=1 only in IDLE.
  - resp_valid=0, resp_data=0, resp_is_load=0.
  - mem_ReadAdd=0, mem_WriteByte=0, mem_WriteWord=0, mem_MemW=00.
  - Counters = 0.
- IDLE:
  - On req_valid && req_ready at edge N, register op, signed, addr and wdata, then go to ACCESS.
  - Request inputs are don't-care when not accepted.
- ACCESS (cycle N+1):
  - mem_ReadAdd = registered addr.
  - mem_WriteByte = wdata[8:0]; mem_WriteWord = wdata.
  - mem_MemW is 01 for store byte, 10 for store word, 00 for loads. It is asserted for exactly this one cycle, so the memory commits the write at edge N+2.
  - Loads capture at edge N+2:
    - load word: resp_data = mem_Word.
    - load byte: resp_data = {7 copies of mem_Byte[8], mem_Byte} if signed, else {7'b0, mem_Byte}.
  - Stores set resp_data = 0.
  - Go to RESP.
- RESP:
  - resp_valid=1 from edge N+2 and held, with resp_data stable, until resp_valid && resp_ready.
  - On that handshake edge: go to IDLE and increment load_cnt or store_cnt, each saturating at all-ones.
- mem_MemW is 00 in every state except a store's ACCESS cycle. mem_ReadAdd holds the last address between requests.
- Minimum request-to-request spacing is 3 cycles, with no overlap. A new request is never accepted during ACCESS or RESP.
- If resp_ready is already high when resp_valid rises, the response completes at the next edge (1 RESP cycle).
- Reset mid-operation, asynchronous:
  - mem_MemW drops to 00 immediately; the write is aborted if the edge has not occurred.
  - No response is issued and the FSM returns to IDLE.
  - Counters clear.
- Widths:
  - Store byte truncates wdata[15:9] silently.
  - Address is 4 bits, with no wrap or alignment checks; entry 15 is valid.

Test Plan:
- Reset, then store word addr 3 wdata 0xBEEF -> mem_MemW=10 for exactly one cycle at N+1 with mem_ReadAdd=3; resp_valid at N+2, resp_data=0, resp_is_load=0; store_cnt=1.
- Load word addr 3, with memory model returning 0xBEEF -> resp_data=0xBEEF, resp_is_load=1, mem_MemW=00 throughout; load_cnt=1.
- Load byte addr 15 with mem_Byte=9'h1A5 -> signed gives resp_data=0xFFA5; unsigned gives 0x01A5.
- Store byte addr 0 wdata 0xFE12 -> mem_MemW=01, mem_WriteByte=0x012; req_ready stays 0 until the response handshake.
- Hold resp_ready=0 for 5 cycles -> resp_valid and resp_data stable; a second req_valid is not accepted. Release -> returns to IDLE and the next request is accepted.
- Assert rst during a store's ACCESS cycle -> mem_MemW=00 immediately, no resp_valid, counters 0. Then run 260 loads with CNT_W=8 -> load_cnt saturates at 255.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store sequencer between the datapath and the 16-entry byte/word data
// memory. Takes one request at a time, drives the memory ports for a single
// access cycle, captures read data, extends byte loads to 16 bits and returns
// a response. Saturating load/store counters are kept for debug.
module load_store_unit #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic             req_signed,
   input  logic [3:0]       req_addr,
   input  logic [15:0]      req_wdata,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [15:0]      resp_data,
   output logic             resp_is_load,
   output logic [3:0]       mem_ReadAdd,
   output logic [8:0]       mem_WriteByte,
   output logic [15:0]      mem_WriteWord,
   output logic [1:0]       mem_MemW,
   input  logic [8:0]       mem_Byte,
   input  logic [15:0]      mem_Word,
   output logic [CNT_W-1:0] load_cnt,
   output logic [CNT_W-1:0] store_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   localparam logic [1:0] OP_LOAD_BYTE  = 2'b00;
   localparam logic [1:0] OP_STORE_BYTE = 2'b01;
   localparam logic [1:0] OP_STORE_WORD = 2'b10;
   localparam logic [1:0] OP_LOAD_WORD  = 2'b11;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t      state;
   state_t      next_state;
   logic [1:0]  op_q;
   logic        signed_q;
   logic [3:0]  addr_q;
   logic [15:0] wdata_q;
   logic [15:0] data_q;
   logic        is_load_q;
   logic        accept;
   logic        resp_done;
   logic        op_is_load;
   logic [15:0] load_value;

   assign accept     = req_valid && req_ready;
   assign resp_done  = resp_valid && resp_ready;
   assign op_is_load = (op_q == OP_LOAD_BYTE) || (op_q == OP_LOAD_WORD);

   // The address register doubles as the memory address, so the last address
   // stays on the bus between requests.
   assign mem_ReadAdd   = addr_q;
   assign mem_WriteByte = wdata_q[8:0];
   assign mem_WriteWord = wdata_q;
   assign resp_data     = data_q;
   assign resp_is_load  = is_load_q;

   // State register; reset returns to IDLE at once, aborting any access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: one access cycle, then hold the response until taken.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = ACCESS;
         ACCESS:  next_state = RESP;
         RESP:    if (resp_done) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Handshake and write-strobe outputs; the write mode is only ever non-zero
   // during a store's single access cycle.
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_MemW   = 2'b00;
      case (state)
         IDLE:   req_ready = !rst;
         ACCESS: begin
            if (!rst && op_q == OP_STORE_BYTE) mem_MemW = 2'b01;
            if (!rst && op_q == OP_STORE_WORD) mem_MemW = 2'b10;
         end
         RESP:    resp_valid = 1'b1;
         default: ;
      endcase
   end

   // Capture the request fields when the request is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= OP_LOAD_BYTE;
         signed_q <= 1'b0;
         addr_q   <= 4'd0;
         wdata_q  <= 16'd0;
      end else if (accept) begin
         op_q     <= req_op;
         signed_q <= req_signed;
         addr_q   <= req_addr;
         wdata_q  <= req_wdata;
      end
   end

   // Extend the 9-bit byte read data to 16 bits or pass the word through.
   always_comb begin
      load_value = 16'd0;
      case (op_q)
         OP_LOAD_WORD: load_value = mem_Word;
         OP_LOAD_BYTE: load_value = signed_q ? {{7{mem_Byte[8]}}, mem_Byte}
                                             : {7'd0, mem_Byte};
         default:      load_value = 16'd0;
      endcase
   end

   // Register the response at the end of the access cycle; stores return zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q    <= 16'd0;
         is_load_q <= 1'b0;
      end else if (state == ACCESS) begin
         data_q    <= load_value;
         is_load_q <= op_is_load;
      end
   end

   // Count completed operations on the response handshake, saturating at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_cnt  <= '0;
         store_cnt <= '0;
      end else if (resp_done) begin
         if (is_load_q && load_cnt != '1) load_cnt <= load_cnt + CNT_ONE;
         if (!is_load_q && store_cnt != '1) store_cnt <= store_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a bench-owned memory model sits on
// the memory ports and a scoreboard queue holds expected responses.
module tb_load_store_unit;

   typedef struct {
      logic [15:0] data;
      logic        is_load;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic        req_signed;
   logic [3:0]  req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_data;
   logic        resp_is_load;
   logic [3:0]  mem_ReadAdd;
   logic [8:0]  mem_WriteByte;
   logic [15:0] mem_WriteWord;
   logic [1:0]  mem_MemW;
   logic [8:0]  mem_Byte;
   logic [15:0] mem_Word;
   logic [7:0]  load_cnt;
   logic [7:0]  store_cnt;

   logic [15:0] mem_arr [16];
   exp_t        exp_q [$];
   int          checks;
   int          errors;
   int          exp_load;
   int          exp_store;

   load_store_unit #(.CNT_W(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_signed    (req_signed),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_data     (resp_data),
      .resp_is_load  (resp_is_load),
      .mem_ReadAdd   (mem_ReadAdd),
      .mem_WriteByte (mem_WriteByte),
      .mem_WriteWord (mem_WriteWord),
      .mem_MemW      (mem_MemW),
      .mem_Byte      (mem_Byte),
      .mem_Word      (mem_Word),
      .load_cnt      (load_cnt),
      .store_cnt     (store_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: combinational read, write committed on the clock edge.
   assign mem_Word = mem_arr[mem_ReadAdd];
   assign mem_Byte = mem_arr[mem_ReadAdd][8:0];

   always @(posedge clk) begin
      if (mem_MemW == 2'b10) mem_arr[mem_ReadAdd] <= mem_WriteWord;
      else if (mem_MemW == 2'b01) mem_arr[mem_ReadAdd][8:0] <= mem_WriteByte;
   end

   // Drive one request, wait (bounded) for acceptance and record the expected
   // response. Returns at the falling edge inside the access cycle.
   task automatic drive_request(input logic [1:0] op, input logic sgn,
                                input logic [3:0] addr, input logic [15:0] wdata,
                                input logic [15:0] exp_data);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk);
      req_valid  = 1'b1;
      req_op     = op;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!req_ready) begin
         errors++;
         $display("[TB] FAIL req_accept_timeout: req_ready=%b required 1", req_ready);
      end
      e.data    = exp_data;
      e.is_load = (op == 2'b00) || (op == 2'b11);
      exp_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Wait (bounded) for a response, hold it for 'hold' cycles, then take it.
   task automatic wait_response(input int hold, output logic [15:0] d,
                                output logic il, output bit timeout);
      int n;
      n = 0;
      timeout = 1'b0;
      d  = 16'd0;
      il = 1'b0;
      while (!resp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!resp_valid) begin
         timeout = 1'b1;
         return;
      end
      repeat (hold) @(negedge clk);
      d  = resp_data;
      il = resp_is_load;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   // Pop the scoreboard and compare a collected response against it.
   task automatic score_response(input string name, input logic [15:0] d,
                                 input logic il, input bit timeout);
      exp_t e;
      checks++;
      if (timeout || exp_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL %s_resp: timeout=%0d queued=%0d required a response",
                  name, timeout, exp_q.size());
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         return;
      end
      e = exp_q.pop_front();
      if (d !== e.data || il !== e.is_load) begin
         errors++;
         $display("[TB] FAIL %s_resp: data=%h is_load=%b required data=%h is_load=%b",
                  name, d, il, e.data, e.is_load);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0 || mem_MemW !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_hold: ready=%b valid=%b memw=%b required 0 0 00",
                  req_ready, resp_valid, mem_MemW);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || resp_data !== 16'd0 || resp_is_load !== 1'b0 ||
          mem_ReadAdd !== 4'd0 || mem_WriteWord !== 16'd0 || mem_WriteByte !== 9'd0 ||
          load_cnt !== 8'd0 || store_cnt !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset_state: ready=%b data=%h il=%b addr=%h ww=%h wb=%h lc=%0d sc=%0d required 1 0000 0 0 0000 000 0 0",
                  req_ready, resp_data, resp_is_load, mem_ReadAdd, mem_WriteWord,
                  mem_WriteByte, load_cnt, store_cnt);
      end
   endtask

   task automatic test_store_word();
      logic [15:0] d;
      logic il;
      bit to;
      drive_request(2'b10, 1'b0, 4'd3, 16'hBEEF, 16'h0000);
      checks++;
      if (mem_MemW !== 2'b10 || mem_ReadAdd !== 4'd3 || mem_WriteWord !== 16'hBEEF ||
          resp_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL sw_access: memw=%b addr=%h ww=%h valid=%b required 10 3 beef 0",
                  mem_MemW, mem_ReadAdd, mem_WriteWord, resp_valid);
      end
      @(negedge clk);
      checks++;
      if (mem_MemW !== 2'b00 || resp_valid !== 1'b1 || resp_data !== 16'h0000 ||
          resp_is_load !== 1'b0) begin
         errors++;
         $display("[TB] FAIL sw_resp_cycle: memw=%b valid=%b data=%h il=%b required 00 1 0000 0",
                  mem_MemW, resp_valid, resp_data, resp_is_load);
      end
      wait_response(0, d, il, to);
      score_response("sw", d, il, to);
      exp_store++;
      checks++;
      if (store_cnt !== 8'(exp_store) || mem_arr[3] !== 16'hBEEF) begin
         errors++;
         $display("[TB] FAIL sw_commit: store_cnt=%0d mem3=%h required %0d beef",
                  store_cnt, mem_arr[3], exp_store);
      end
   endtask

   task automatic test_load_word();
      logic [15:0] d;
      logic il;
      bit to;
      bit saw_write;
      saw_write = 1'b0;
      drive_request(2'b11, 1'b0, 4'd3, 16'h1234, 16'hBEEF);
      if (mem_MemW !== 2'b00) saw_write = 1'b1;
      @(negedge clk);
      if (mem_MemW !== 2'b00) saw_write = 1'b1;
      checks++;
      if (saw_write) begin
         errors++;
         $display("[TB] FAIL lw_no_write: memw=%b required 00", mem_MemW);
      end
      wait_response(0, d, il, to);
      score_response("lw", d, il, to);
      exp_load++;
      checks++;
      if (load_cnt !== 8'(exp_load)) begin
         errors++;
         $display("[TB] FAIL lw_count: load_cnt=%0d required %0d", load_cnt, exp_load);
      end
   endtask

   task automatic test_store_byte();
      logic [15:0] d;
      logic il;
      bit to;
      drive_request(2'b01, 1'b0, 4'd0, 16'hFE12, 16'h0000);
      checks++;
      if (mem_MemW !== 2'b01 || mem_WriteByte !== 9'h012 || mem_ReadAdd !== 4'd0 ||
          req_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL sb_access: memw=%b wb=%h addr=%h ready=%b required 01 012 0 0",
                  mem_MemW, mem_WriteByte, mem_ReadAdd, req_ready);
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL sb_ready_resp: ready=%b required 0", req_ready);
      end
      wait_response(0, d, il, to);
      score_response("sb", d, il, to);
      exp_store++;
      checks++;
      if (req_ready !== 1'b1 || store_cnt !== 8'(exp_store)) begin
         errors++;
         $display("[TB] FAIL sb_after: ready=%b store_cnt=%0d required 1 %0d",
                  req_ready, store_cnt, exp_store);
      end
      // Byte load back from entry 0 returns the truncated 9-bit value.
      drive_request(2'b00, 1'b0, 4'd0, 16'h0000, 16'h0012);
      wait_response(0, d, il, to);
      score_response("lb_addr0", d, il, to);
      exp_load++;
   endtask

   task automatic test_load_byte();
      logic [15:0] d;
      logic il;
      bit to;
      drive_request(2'b01, 1'b0, 4'd15, 16'h01A5, 16'h0000);
      wait_response(0, d, il, to);
      score_response("sb_addr15", d, il, to);
      exp_store++;
      drive_request(2'b00, 1'b1, 4'd15, 16'h0000, 16'hFFA5);
      wait_response(1, d, il, to);
      score_response("lb_signed", d, il, to);
      exp_load++;
      drive_request(2'b00, 1'b0, 4'd15, 16'h0000, 16'h01A5);
      wait_response(0, d, il, to);
      score_response("lb_unsigned", d, il, to);
      exp_load++;
      checks++;
      if (load_cnt !== 8'(exp_load) || store_cnt !== 8'(exp_store)) begin
         errors++;
         $display("[TB] FAIL lb_counts: load_cnt=%0d store_cnt=%0d required %0d %0d",
                  load_cnt, store_cnt, exp_load, exp_store);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] d;
      logic il;
      bit to;
      bit bad;
      exp_t e;
      bad = 1'b0;
      drive_request(2'b11, 1'b0, 4'd3, 16'h0000, 16'hBEEF);
      @(negedge clk);
      // A second request is presented while the first response is stalled.
      req_valid  = 1'b1;
      req_op     = 2'b10;
      req_signed = 1'b0;
      req_addr   = 4'd7;
      req_wdata  = 16'h5A5A;
      resp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (resp_valid !== 1'b1 || resp_data !== 16'hBEEF || req_ready !== 1'b0 ||
             mem_MemW !== 2'b00) bad = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (bad) begin
         errors++;
         $display("[TB] FAIL bp_stall: valid=%b data=%h ready=%b memw=%b required 1 beef 0 00",
                  resp_valid, resp_data, req_ready, mem_MemW);
      end
      d  = resp_data;
      il = resp_is_load;
      resp_ready = 1'b1;
      score_response("bp_first", d, il, !resp_valid);
      exp_load++;
      @(negedge clk);
      resp_ready = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_release: ready=%b valid=%b required 1 0", req_ready, resp_valid);
      end
      e.data    = 16'h0000;
      e.is_load = 1'b0;
      exp_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (mem_MemW !== 2'b10 || mem_ReadAdd !== 4'd7 || mem_WriteWord !== 16'h5A5A) begin
         errors++;
         $display("[TB] FAIL bp_second_access: memw=%b addr=%h ww=%h required 10 7 5a5a",
                  mem_MemW, mem_ReadAdd, mem_WriteWord);
      end
      wait_response(0, d, il, to);
      score_response("bp_second", d, il, to);
      exp_store++;
      checks++;
      if (mem_arr[7] !== 16'h5A5A || load_cnt !== 8'(exp_load) || store_cnt !== 8'(exp_store)) begin
         errors++;
         $display("[TB] FAIL bp_commit: mem7=%h lc=%0d sc=%0d required 5a5a %0d %0d",
                  mem_arr[7], load_cnt, store_cnt, exp_load, exp_store);
      end
   endtask

   task automatic test_reset_mid();
      bit bad;
      bad = 1'b0;
      drive_request(2'b10, 1'b0, 4'd5, 16'h1234, 16'h0000);
      void'(exp_q.pop_back());
      checks++;
      if (mem_MemW !== 2'b10) begin
         errors++;
         $display("[TB] FAIL rm_pre: memw=%b required 10", mem_MemW);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (mem_MemW !== 2'b00 || resp_valid !== 1'b0 || req_ready !== 1'b0 ||
          load_cnt !== 8'd0 || store_cnt !== 8'd0) begin
         errors++;
         $display("[TB] FAIL rm_async: memw=%b valid=%b ready=%b lc=%0d sc=%0d required 00 0 0 0 0",
                  mem_MemW, resp_valid, req_ready, load_cnt, store_cnt);
      end
      exp_load  = 0;
      exp_store = 0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad || mem_arr[5] === 16'h1234) begin
         errors++;
         $display("[TB] FAIL rm_after: valid=%b ready=%b mem5=%h required 0 1 and no write",
                  resp_valid, req_ready, mem_arr[5]);
      end
   endtask

   task automatic test_saturation();
      logic [15:0] d;
      logic il;
      bit to;
      for (int i = 0; i < 260; i++) begin
         if (i % 2 == 0) drive_request(2'b11, 1'b0, 4'd3, 16'h0000, 16'hBEEF);
         else            drive_request(2'b00, 1'b0, 4'd15, 16'h0000, 16'h01A5);
         wait_response(0, d, il, to);
         score_response("sat_load", d, il, to);
         exp_load = (exp_load == 255) ? 255 : exp_load + 1;
         if (i == 254) begin
            checks++;
            if (load_cnt !== 8'd255) begin
               errors++;
               $display("[TB] FAIL sat_reach: load_cnt=%0d required 255", load_cnt);
            end
         end
      end
      checks++;
      if (load_cnt !== 8'(exp_load) || store_cnt !== 8'(exp_store)) begin
         errors++;
         $display("[TB] FAIL sat_hold: load_cnt=%0d store_cnt=%0d required %0d %0d",
                  load_cnt, store_cnt, exp_load, exp_store);
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      exp_load   = 0;
      exp_store  = 0;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_op     = 2'b00;
      req_signed = 1'b0;
      req_addr   = 4'd0;
      req_wdata  = 16'd0;
      resp_ready = 1'b0;
      test_reset();
      test_store_word();
      test_load_word();
      test_store_byte();
      test_load_byte();
      test_back_to_back();
      test_reset_mid();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
